ysyx_23060124_lsu_mc: RTL and testbench

//  Multi-cycle, handshaked load/store unit; successor to the single-cycle DPI LSU.

---
 rtl/ysyx_23060124_lsu_mc.sv | 200 ++++++++++++++++++++
 tb/tb_ysyx_23060124_lsu_mc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_lsu_mc.sv
// ysyx_23060124_lsu_mc: multi-cycle handshaked load/store unit between EXU and the data bus.
// Issues one aligned bus access per request, bounded by a timeout, and returns size/sign-adjusted data.
`ifndef ysyx_23060124_OPT_LSU_LB
`define ysyx_23060124_OPT_LSU_LB  1
`define ysyx_23060124_OPT_LSU_LH  2
`define ysyx_23060124_OPT_LSU_LW  3
`define ysyx_23060124_OPT_LSU_LBU 4
`define ysyx_23060124_OPT_LSU_LHU 5
`define ysyx_23060124_OPT_LSU_SB  1
`define ysyx_23060124_OPT_LSU_SH  2
`define ysyx_23060124_OPT_LSU_SW  3
`endif

module ysyx_23060124_lsu_mc #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int OPT_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPT_WIDTH-1:0] load_opt,
  input  logic [OPT_WIDTH-1:0] store_opt,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    lsu_res,
  output logic [1:0]           lsu_err,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_wen,
  output logic [ADDR_W-1:0]    mem_req_addr,
  output logic [DATA_W-1:0]    mem_req_wdata,
  output logic [DATA_W/8-1:0]  mem_req_wstrb,
  input  logic                 mem_rsp_valid,
  input  logic [DATA_W-1:0]    mem_rsp_rdata,
  input  logic                 mem_rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  localparam logic [1:0] ERR_OK = 2'd0, ERR_ILL = 2'd1, ERR_BUS = 2'd2, ERR_TMO = 2'd3;

  localparam logic [OPT_WIDTH-1:0] OPT_LB  = OPT_WIDTH'(`ysyx_23060124_OPT_LSU_LB);
  localparam logic [OPT_WIDTH-1:0] OPT_LH  = OPT_WIDTH'(`ysyx_23060124_OPT_LSU_LH);
  localparam logic [OPT_WIDTH-1:0] OPT_LW  = OPT_WIDTH'(`ysyx_23060124_OPT_LSU_LW);
  localparam logic [OPT_WIDTH-1:0] OPT_LBU = OPT_WIDTH'(`ysyx_23060124_OPT_LSU_LBU);
  localparam logic [OPT_WIDTH-1:0] OPT_LHU = OPT_WIDTH'(`ysyx_23060124_OPT_LSU_LHU);
  localparam logic [OPT_WIDTH-1:0] OPT_SB  = OPT_WIDTH'(`ysyx_23060124_OPT_LSU_SB);
  localparam logic [OPT_WIDTH-1:0] OPT_SH  = OPT_WIDTH'(`ysyx_23060124_OPT_LSU_SH);
  localparam logic [OPT_WIDTH-1:0] OPT_SW  = OPT_WIDTH'(`ysyx_23060124_OPT_LSU_SW);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       size_q;
  logic             sext_q;
  logic             store_q;
  logic [OFF_W-1:0] off_q;

  logic             is_load;
  logic             is_store;
  logic             op_ok;
  logic             sext;
  logic             misaligned;
  logic [1:0]       size;
  logic [OFF_W-1:0] off;
  logic [NB-1:0]    strb_base;

  // Accept-time decode of the incoming request.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    is_load   = (load_opt != '0);
    is_store  = (store_opt != '0);
    size      = SZ_B;
    sext      = 1'b0;
    op_ok     = 1'b1;
    off       = addr[OFF_W-1:0];
    strb_base = '0;
    if (is_load) begin
      case (load_opt)
        OPT_LB:  begin size = SZ_B; sext = 1'b1; end
        OPT_LH:  begin size = SZ_H; sext = 1'b1; end
        OPT_LW:  begin size = SZ_W; sext = 1'b1; end
        OPT_LBU: size = SZ_B;
        OPT_LHU: size = SZ_H;
        default: op_ok = 1'b0;
      endcase
    end else if (is_store) begin
      case (store_opt)
        OPT_SB:  size = SZ_B;
        OPT_SH:  size = SZ_H;
        OPT_SW:  size = SZ_W;
        default: op_ok = 1'b0;
      endcase
    end
    misaligned = ((size == SZ_H) && addr[0]) || ((size == SZ_W) && (addr[1:0] != 2'b00));
    case (size)
      SZ_B:    strb_base = NB'(4'h1);
      SZ_H:    strb_base = NB'(4'h3);
      default: strb_base = NB'(4'hF);
    endcase
  end

  logic [DATA_W-1:0] rsp_sh;
  logic [DATA_W-1:0] load_val;

  // Right-align the addressed lane, then sign- or zero-extend to full width.
  always_comb begin
    rsp_sh = mem_rsp_rdata >> {off_q, 3'b000};
    case (size_q)
      SZ_B:    load_val = sext_q ? DATA_W'($signed(rsp_sh[7:0]))  : DATA_W'(rsp_sh[7:0]);
      SZ_H:    load_val = sext_q ? DATA_W'($signed(rsp_sh[15:0])) : DATA_W'(rsp_sh[15:0]);
      default: load_val = sext_q ? DATA_W'($signed(rsp_sh[31:0])) : DATA_W'(rsp_sh[31:0]);
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      lsu_res       <= '0;
      lsu_err       <= ERR_OK;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      size_q        <= SZ_B;
      sext_q        <= 1'b0;
      store_q       <= 1'b0;
      off_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            lsu_res <= '0;
            if (!is_load && !is_store) begin
              lsu_err <= ERR_OK;
              state   <= DONE;
            end else if ((is_load && is_store) || !op_ok || misaligned) begin
              lsu_err <= ERR_ILL;
              state   <= DONE;
            end else begin
              lsu_err       <= ERR_OK;
              mem_req_wen   <= is_store;
              mem_req_addr  <= {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
              mem_req_wdata <= is_store ? (wdata << {off, 3'b000}) : '0;
              mem_req_wstrb <= is_store ? (strb_base << off) : '0;
              size_q        <= size;
              sext_q        <= sext;
              store_q       <= is_store;
              off_q         <= off;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A response in the final timeout cycle still wins over the timeout.
          if (mem_rsp_valid) begin
            state <= DONE;
            if (mem_rsp_err) begin
              lsu_err <= ERR_BUS;
              lsu_res <= '0;
            end else begin
              lsu_err <= ERR_OK;
              lsu_res <= store_q ? '0 : load_val;
            end
          end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
            lsu_err <= ERR_TMO;
            lsu_res <= '0;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign out_valid     = (state == DONE);

endmodule

// File: tb/tb_ysyx_23060124_lsu_mc.sv
// Self-checking bench for ysyx_23060124_lsu_mc: table of load/store vectors with a result
// scoreboard, plus hand-written timeout, stray-response and mid-transaction reset sequences.
`timescale 1ns/1ps
`ifndef ysyx_23060124_OPT_LSU_LB
`define ysyx_23060124_OPT_LSU_LB  1
`define ysyx_23060124_OPT_LSU_LH  2
`define ysyx_23060124_OPT_LSU_LW  3
`define ysyx_23060124_OPT_LSU_LBU 4
`define ysyx_23060124_OPT_LSU_LHU 5
`define ysyx_23060124_OPT_LSU_SB  1
`define ysyx_23060124_OPT_LSU_SH  2
`define ysyx_23060124_OPT_LSU_SW  3
`endif

module tb_ysyx_23060124_lsu_mc;

  localparam logic [3:0] LB  = 4'(`ysyx_23060124_OPT_LSU_LB);
  localparam logic [3:0] LH  = 4'(`ysyx_23060124_OPT_LSU_LH);
  localparam logic [3:0] LW  = 4'(`ysyx_23060124_OPT_LSU_LW);
  localparam logic [3:0] LBU = 4'(`ysyx_23060124_OPT_LSU_LBU);
  localparam logic [3:0] LHU = 4'(`ysyx_23060124_OPT_LSU_LHU);
  localparam logic [3:0] SB  = 4'(`ysyx_23060124_OPT_LSU_SB);
  localparam logic [3:0] SH  = 4'(`ysyx_23060124_OPT_LSU_SH);
  localparam logic [3:0] SW  = 4'(`ysyx_23060124_OPT_LSU_SW);

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  load_opt;
  logic [3:0]  store_opt;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] lsu_res;
  logic [1:0]  lsu_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  ysyx_23060124_lsu_mc #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .OPT_WIDTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .load_opt(load_opt), .store_opt(store_opt), .addr(addr), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready), .lsu_res(lsu_res), .lsu_err(lsu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  lop;
    logic [3:0]  sop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rerr;
    int          k;        // cycles mem_req_ready is held low
    int          d;        // WAIT cycles before the response pulse
    int          m;        // cycles out_ready is held low
    logic        no_rsp;
    logic        exp_bus;
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_res;
    logic [1:0]  exp_err;
    int          exp_lat;  // cycles from accept edge until out_valid
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  err;
  } res_t;

  localparam int NV = 18;
  vec_t vecs[NV];
  res_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic run_txn(input vec_t v, input int id);
    int   c;
    int   stall;
    int   wcnt;
    logic in_wait;
    logic saw_req;
    res_t e;
    c = 0; stall = 0; wcnt = 0; in_wait = 1'b0; saw_req = 1'b0;
    @(negedge clock);
    check($sformatf("v%0d in_ready idle", id), 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    load_opt  = v.lop;
    store_opt = v.sop;
    addr      = v.addr;
    wdata     = v.wdata;
    exp_q.push_back('{res: v.exp_res, err: v.exp_err});
    @(negedge clock);
    in_valid  = 1'b0;
    load_opt  = '0;
    store_opt = '0;
    addr      = '0;
    wdata     = '0;
    c = 1;
    while (!out_valid && c < 60) begin
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
      if (in_wait) begin
        if (!v.no_rsp && wcnt == v.d) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = v.rdata;
          mem_rsp_err   = v.rerr;
        end
        wcnt++;
      end
      if (mem_req_valid) begin
        saw_req = 1'b1;
        check($sformatf("v%0d req_addr", id), 64'(mem_req_addr), 64'(v.exp_addr));
        check($sformatf("v%0d req_wdata", id), 64'(mem_req_wdata), 64'(v.exp_wdata));
        check($sformatf("v%0d req_wen_wstrb", id), 64'({mem_req_wen, mem_req_wstrb}),
              64'({v.exp_wen, v.exp_wstrb}));
        if (stall >= v.k) begin
          mem_req_ready = 1'b1;
          in_wait       = 1'b1;
        end
        stall++;
      end
      @(negedge clock);
      c++;
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    check($sformatf("v%0d out_valid seen", id), 64'(out_valid), 64'd1);
    check($sformatf("v%0d latency", id), 64'(c), 64'(v.exp_lat));
    check($sformatf("v%0d bus access", id), 64'(saw_req), 64'(v.exp_bus));
    check($sformatf("v%0d in_ready in done", id), 64'(in_ready), 64'd0);
    check($sformatf("v%0d sb depth", id), 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("v%0d lsu_res", id), 64'(lsu_res), 64'(e.res));
      check($sformatf("v%0d lsu_err", id), 64'(lsu_err), 64'(e.err));
      for (int j = 0; j < v.m; j++) begin
        @(negedge clock);
        check($sformatf("v%0d hold valid", id), 64'({out_valid, in_ready}), 64'b10);
        check($sformatf("v%0d hold result", id), 64'({lsu_res, lsu_err}), 64'({e.res, e.err}));
      end
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check($sformatf("v%0d back to idle", id), 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          lop  sop addr          wdata         rdata         rerr k  d  m  nrsp bus wen exp_addr      exp_wdata     strb   exp_res       err lat
    vecs[0]  = '{LW,  0, 32'h80000004, 32'h0,        32'hDEADBEEF, 0,   0, 0, 0, 0,   1,  0,  32'h80000004, 32'h0,        4'h0,  32'hDEADBEEF, 0,  3};
    vecs[1]  = '{LB,  0, 32'h80000003, 32'h0,        32'h80FFFFFF, 0,   0, 0, 0, 0,   1,  0,  32'h80000000, 32'h0,        4'h0,  32'hFFFFFF80, 0,  3};
    vecs[2]  = '{LBU, 0, 32'h80000003, 32'h0,        32'h80FFFFFF, 0,   0, 0, 0, 0,   1,  0,  32'h80000000, 32'h0,        4'h0,  32'h00000080, 0,  3};
    vecs[3]  = '{0,  SH, 32'h80000002, 32'h1234ABCD, 32'h0,        0,   0, 0, 0, 0,   1,  1,  32'h80000000, 32'hABCD0000, 4'hC,  32'h0,        0,  3};
    vecs[4]  = '{LW,  0, 32'h80000002, 32'h0,        32'h0,        0,   0, 0, 0, 0,   0,  0,  32'h0,        32'h0,        4'h0,  32'h0,        1,  1};
    vecs[5]  = '{LW,  0, 32'h80000010, 32'h0,        32'h0,        0,   0, 0, 0, 1,   1,  0,  32'h80000010, 32'h0,        4'h0,  32'h0,        3,  6};
    vecs[6]  = '{LH,  0, 32'h80000002, 32'h0,        32'h80011234, 0,   3, 1, 2, 0,   1,  0,  32'h80000000, 32'h0,        4'h0,  32'hFFFF8001, 0,  7};
    vecs[7]  = '{LHU, 0, 32'h80000000, 32'h0,        32'h1234F00D, 0,   0, 0, 1, 0,   1,  0,  32'h80000000, 32'h0,        4'h0,  32'h0000F00D, 0,  3};
    vecs[8]  = '{0,  SB, 32'h80000001, 32'h000000A5, 32'h0,        0,   0, 0, 0, 0,   1,  1,  32'h80000000, 32'h0000A500, 4'h2,  32'h0,        0,  3};
    vecs[9]  = '{0,  SW, 32'h80000008, 32'hCAFEF00D, 32'h0,        1,   0, 0, 0, 0,   1,  1,  32'h80000008, 32'hCAFEF00D, 4'hF,  32'h0,        2,  3};
    vecs[10] = '{LW,  0, 32'h8000000C, 32'h0,        32'h11111111, 1,   1, 2, 0, 0,   1,  0,  32'h8000000C, 32'h0,        4'h0,  32'h0,        2,  6};
    vecs[11] = '{0,   0, 32'h80000003, 32'h0,        32'h0,        0,   0, 0, 0, 0,   0,  0,  32'h0,        32'h0,        4'h0,  32'h0,        0,  1};
    vecs[12] = '{LW, SW, 32'h80000000, 32'h0,        32'h0,        0,   0, 0, 0, 0,   0,  0,  32'h0,        32'h0,        4'h0,  32'h0,        1,  1};
    vecs[13] = '{0,  SW, 32'h80000001, 32'h0,        32'h0,        0,   0, 0, 0, 0,   0,  0,  32'h0,        32'h0,        4'h0,  32'h0,        1,  1};
    vecs[14] = '{LH,  0, 32'h80000001, 32'h0,        32'h0,        0,   0, 0, 0, 0,   0,  0,  32'h0,        32'h0,        4'h0,  32'h0,        1,  1};
    vecs[15] = '{LB,  0, 32'h80000002, 32'h0,        32'h007F0000, 0,   0, 0, 0, 0,   1,  0,  32'h80000000, 32'h0,        4'h0,  32'h0000007F, 0,  3};
    vecs[16] = '{LBU, 0, 32'h80000020, 32'h0,        32'h0,        0,   2, 0, 0, 1,   1,  0,  32'h80000020, 32'h0,        4'h0,  32'h0,        3,  8};
    vecs[17] = '{LW,  0, 32'h80000014, 32'h0,        32'h0BADF00D, 0,   0, 3, 0, 0,   1,  0,  32'h80000014, 32'h0,        4'h0,  32'h0BADF00D, 0,  6};

    reset         = 1'b1;
    in_valid      = 1'b0;
    load_opt      = '0;
    store_opt     = '0;
    addr          = '0;
    wdata         = '0;
    out_ready     = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    mem_rsp_err   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset handshake", 64'({in_ready, out_valid, mem_req_valid, mem_req_wen}), 64'b1000);
    check("reset req fields", 64'({mem_req_addr, mem_req_wstrb}), 64'd0);
    check("reset req wdata", 64'(mem_req_wdata), 64'd0);
    check("reset result", 64'({lsu_res, lsu_err}), 64'd0);

    for (int i = 0; i < NV; i++) run_txn(vecs[i], i);

    // Timeout, then a late response while idle must be dropped.
    run_txn(vecs[5], 100);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hFFFFFFFF;
    mem_rsp_err   = 1'b1;
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    check("late rsp ignored", 64'({out_valid, in_ready, mem_req_valid}), 64'b010);
    @(negedge clock);
    check("late rsp still idle", 64'({out_valid, in_ready}), 64'b01);
    run_txn(vecs[0], 101);

    // Reset while waiting for a response abandons the load.
    @(negedge clock);
    in_valid = 1'b1;
    load_opt = LW;
    addr     = 32'h80000040;
    @(negedge clock);
    in_valid = 1'b0;
    load_opt = '0;
    check("rst-seq in REQ", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    check("rst-seq in WAIT", 64'({mem_req_valid, out_valid, in_ready}), 64'b000);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst-seq idle", 64'({in_ready, out_valid, mem_req_valid}), 64'b100);
    check("rst-seq result", 64'({lsu_res, lsu_err}), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h5A5A5A5A;
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    check("rst-seq stray rsp", 64'({out_valid, in_ready}), 64'b01);
    run_txn(vecs[1], 102);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
